// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake bundle between the fetch stage, the fetch queue
// and decode. The slave modport is the queue's view; the master modport is the
// view of whatever drives the fetch side and consumes the decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // redirect: discard every queued entry
  logic          flush;

  // fetch side
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_ready;

  // decode side
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_ready;

  // occupancy
  logic [CW-1:0] count;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_pc,
    input  in_inst,
    output in_ready,
    output out_valid,
    output out_pc,
    output out_inst,
    input  out_ready,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    output in_pc,
    output in_inst,
    input  in_ready,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    output out_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- small circular buffer of {pc, inst} pairs between
// instruction fetch and decode. DEPTH must be a power of two in 2..16.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an offered
// entry is presented to decode combinationally in the same cycle and, if
// decode takes it, it is never stored.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,   // asynchronous, active-low
  fetch_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // storage is deliberately left without reset; nothing exposes it while empty
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_in_ready;
  logic          w_enq;
  logic          w_deq;
  logic          w_out_valid;
  logic [31:0]   w_out_pc;
  logic [31:0]   w_out_inst;

  // in_ready is a pure function of state: a full queue never accepts, even
  // while an entry is leaving in the same cycle
  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count < CW'(DEPTH));

  // a dequeue only ever removes a stored entry
  assign w_deq = ~w_empty & bus.out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;

  // empty queue with a live offer: hand it straight through to decode
  assign w_bypass = w_empty & bus.in_valid & ~bus.flush;

  // a bypassed entry that decode takes this cycle is not stored
  assign w_enq = bus.in_valid & w_in_ready & ~(w_bypass & bus.out_ready);

  // head presentation: bypassed offer, stored head, or zeros when idle
  always_comb begin
    w_out_valid = 1'b0;
    w_out_pc    = 32'h0;
    w_out_inst  = 32'h0;
    if (w_bypass) begin
      w_out_valid = 1'b1;
      w_out_pc    = bus.in_pc;
      w_out_inst  = bus.in_inst;
    end else if (!w_empty) begin
      w_out_valid = 1'b1;
      w_out_pc    = r_pc_mem[r_rd_ptr];
      w_out_inst  = r_inst_mem[r_rd_ptr];
    end
  end
`else
  assign w_enq = bus.in_valid & w_in_ready;

  // head presentation: stored head only, zeros when empty (no in->out path)
  always_comb begin
    w_out_valid = 1'b0;
    w_out_pc    = 32'h0;
    w_out_inst  = 32'h0;
    if (!w_empty) begin
      w_out_valid = 1'b1;
      w_out_pc    = r_pc_mem[r_rd_ptr];
      w_out_inst  = r_inst_mem[r_rd_ptr];
    end
  end
`endif

  // write the accepted entry at the tail; a flush discards it
  always_ff @(posedge clk) begin
    if (w_enq && !bus.flush) begin
      r_pc_mem[r_wr_ptr]   <= bus.in_pc;
      r_inst_mem[r_wr_ptr] <= bus.in_inst;
    end
  end

  // pointer and occupancy control; flush overrides any same-cycle transfer,
  // and the power-of-two depth makes the pointer wrap a plain overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_pc;
  assign bus.out_inst  = w_out_inst;
  assign bus.count     = r_count;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1, discard all entries (branch or jump redirect).
REQ-005 The block SHALL have port in_valid, input, 1, the fetch side offers {in_pc, in_inst}.
REQ-006 The block SHALL have port in_pc, input, 32, the PC of the offered instruction.
REQ-007 The block SHALL have port in_inst, input, 32, the instruction word from instruction memory.
REQ-008 The block SHALL have port in_ready, output, 1, an entry is free.
REQ-009 The block SHALL have port out_valid, output, 1, the head entry is presented to decode.
REQ-010 The block SHALL have ports out_pc and out_inst, output, 32 each, carrying the head entry.
REQ-011 The block SHALL have port out_ready, input, 1, decode accepts the head.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1, the current occupancy.

Function
REQ-013 Enqueue SHALL occur when in_valid=1 and in_ready=1 at a rising edge; the entry is written at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-014 Dequeue SHALL occur when out_valid=1 and out_ready=1 at a rising edge; rd_ptr advances modulo DEPTH.
REQ-015 in_ready SHALL equal (count < DEPTH); it depends only on state, and a full queue SHALL NOT accept even when a dequeue happens in the same cycle.
REQ-016 out_valid SHALL equal (count != 0), with out_pc and out_inst read combinationally from the entry at rd_ptr.
REQ-017 out_pc and out_inst SHALL be 32'h0 whenever out_valid=0.
REQ-018 With simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 Entries SHALL leave in strict FIFO order, with no reordering or duplication.
REQ-020 A flush at a rising edge SHALL set count, wr_ptr and rd_ptr to 0, and an enqueue or dequeue in the same cycle SHALL be discarded: flush wins.
REQ-021 After a flush, out_valid SHALL be 0 and in_ready SHALL be 1 from the following cycle.
REQ-022 Entry latency from enqueue to out_valid SHALL be 1 cycle into an empty queue, unless the macro in REQ-027 is defined.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or stale entry.

Reset
REQ-024 While rst=0, count, wr_ptr and rd_ptr SHALL be 0, out_valid SHALL be 0, out_pc and out_inst SHALL be 0, and in_ready SHALL be 1.
REQ-025 Storage array contents SHALL NOT be reset; no output exposes them while count=0.
REQ-026 If rst is asserted mid-operation, all entries SHALL be lost immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro FETCH_QUEUE_BYPASS_EN defined, when count=0, in_valid=1 and flush=0, out_valid SHALL be 1 with out_pc=in_pc and out_inst=in_inst in the same cycle, combinationally.
REQ-028 In that bypass case, if out_ready=1 the entry SHALL be consumed and not stored; otherwise it is enqueued normally.
REQ-029 With FETCH_QUEUE_BYPASS_EN undefined, there SHALL be no combinational path from the in_* ports to the out_* ports, and minimum latency is 1 cycle.

Verification
REQ-030 Reset then idle -> out_valid=0, out_pc=0, in_ready=1, count=0.
REQ-031 Enqueue PCs 0x0, 0x4, 0x8, 0xC with out_ready=0 -> count=4 and in_ready=0; a fifth offer at 0x10 is not accepted; raising out_ready yields 0x0, 0x4, 0x8, 0xC in order.
REQ-032 Hold count=2, with in_valid=1 and out_ready=1 for 10 cycles carrying PCs 0x100..0x124 -> count stays 2, pointers wrap, and output order is preserved.
REQ-033 With count=3, assert flush together with in_valid=1 (in_pc=0x40) -> next cycle count=0 and out_valid=0; 0x40 is never output.
REQ-034 With count=2, drive rst low between clock edges -> out_valid=0 immediately; after release, count=0.
REQ-035 With FETCH_QUEUE_BYPASS_EN, an empty queue, in_valid=1, in_pc=0x80 and out_ready=1 -> out_valid=1 with out_pc=0x80 in the same cycle and count stays 0. Without the macro -> out_valid=1 with out_pc=0x80 one cycle later.
